// File: rtl/if_arith_pipe.sv
// if_arith_pipe: two-stage valid/ready pipeline doing compare-and-arithmetic
// on unsigned operands A and B. The block also has an optional running
// accumulator, and it returns a defined result with a flag on divide-by-zero.
// All arithmetic wraps modulo 2^NBITS.
module if_arith_pipe #(
    parameter int unsigned      NBITS   = 8,
    parameter logic [NBITS-1:0] ACC_RST = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [NBITS-1:0] A,
    input  logic [NBITS-1:0] B,
    input  logic             ACC_EN,
    input  logic             ACC_CLR,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [NBITS-1:0] XOUT,
    output logic             DIVZ
);

    // Handshake and pipeline control
    logic             advance;
    logic             in_fire;

    // Stage-1 registers
    logic             s1_valid;
    logic [NBITS-1:0] s1_a;
    logic [NBITS-1:0] s1_b;
    logic [NBITS-1:0] s1_t1;
    logic             s1_acc_en;
    logic             s1_acc_clr;

    // Combinational stage results
    logic [NBITS-1:0] t1;
    logic [NBITS-1:0] quot;
    logic [NBITS-1:0] t2;
    logic             divz;

    // Accumulator
    logic [NBITS-1:0] acc;
    logic [NBITS-1:0] acc_next;

    // The output stage can take a new beat when it is empty or being drained.
    assign advance  = !OUT_VALID || OUT_READY;
    assign IN_READY = !s1_valid || advance;
    assign in_fire  = IN_VALID && IN_READY;

    // First arithmetic step, computed from the live operands
    always_comb begin
        t1 = '0;
        if (A > B) begin
            t1 = A + A;
        end else if (B > A) begin
            t1 = A - B;
        end else begin
            t1 = A * B;
        end
    end

    // Second arithmetic step. A zero divisor gives an all-ones quotient, which wraps to zero after the +1.
    always_comb begin
        t2   = '0;
        divz = 1'b0;
        quot = (s1_a == '0) ? '1 : (s1_t1 / s1_a);
        if (s1_a > s1_b) begin
            t2 = s1_t1 - s1_a;
        end else if (s1_a < s1_b) begin
            t2 = s1_t1 + s1_a;
        end else begin
            t2   = quot + NBITS'(1);
            divz = (s1_a == '0);
        end
    end

    // Clear applies before the add and only to this beat
    always_comb begin
        acc_next = (s1_acc_clr ? '0 : acc) + t2;
    end

    // Stage-1 register: capture on input transfer, empty when drained with no new beat
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid   <= 1'b1;
            s1_a       <= A;
            s1_b       <= B;
            s1_t1      <= t1;
            s1_acc_en  <= ACC_EN;
            s1_acc_clr <= ACC_CLR;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Output stage and accumulator: hold while stalled, load from stage 1 on advance
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            XOUT      <= '0;
            DIVZ      <= 1'b0;
            acc       <= ACC_RST;
        end else if (advance) begin
            OUT_VALID <= s1_valid;
            if (s1_valid) begin
                DIVZ <= divz;
                if (s1_acc_en) begin
                    acc  <= acc_next;
                    XOUT <= acc_next;
                end else begin
                    XOUT <= t2;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_arith_pipe.sv
// Testbench for if_arith_pipe (NBITS=8). It checks the block against a
// beat-level reference model: a queue of accepted beats plus a model
// accumulator.
module tb_if_arith_pipe;

    logic       CLK = 1'b0;
    logic       RST;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] A;
    logic [7:0] B;
    logic       ACC_EN;
    logic       ACC_CLR;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] XOUT;
    logic       DIVZ;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int macc   = 0;

    typedef struct {
        int a;
        int b;
        bit en;
        bit clr;
        int cyc;
    } beat_t;

    typedef struct {
        int a;
        int b;
        bit en;
        bit clr;
        int x;
        bit d;
    } vec_t;

    beat_t q[$];

    // Values sampled just before each rising edge
    bit         s_in;
    bit         s_out;
    bit         s_valid;
    bit         s_rdy;
    bit         s_ordy;
    logic [7:0] s_x;
    logic       s_d;
    int         s_occ;
    int         s_cyc;

    always #5 CLK = ~CLK;

    if_arith_pipe #(.NBITS(8), .ACC_RST(8'd0)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .A        (A),
        .B        (B),
        .ACC_EN   (ACC_EN),
        .ACC_CLR  (ACC_CLR),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .XOUT     (XOUT),
        .DIVZ     (DIVZ)
    );

    // Advance one cycle. Record the handshakes seen before the edge and log any accepted beat.
    task automatic tick();
        beat_t bt;
        #1;
        s_occ   = q.size();
        s_cyc   = cyc;
        s_rdy   = IN_READY;
        s_ordy  = OUT_READY;
        s_valid = OUT_VALID;
        s_x     = XOUT;
        s_d     = DIVZ;
        s_in    = IN_VALID && IN_READY && !RST;
        s_out   = OUT_VALID && OUT_READY && !RST;
        if (s_in) begin
            bt.a = int'(A); bt.b = int'(B); bt.en = ACC_EN; bt.clr = ACC_CLR; bt.cyc = cyc;
            q.push_back(bt);
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Reference: apply the arithmetic rules to the oldest outstanding beat
    function automatic bit model_pop(output logic [7:0] x, output bit d, output int c);
        beat_t bt;
        int t1;
        int t2;
        x = 8'd0; d = 1'b0; c = 0;
        if (q.size() == 0) return 1'b0;
        bt = q.pop_front();
        c = bt.cyc;
        if (bt.a > bt.b)      t1 = (2 * bt.a) % 256;
        else if (bt.b > bt.a) t1 = (bt.a - bt.b + 256) % 256;
        else                  t1 = (bt.a * bt.b) % 256;
        if (bt.a > bt.b)      t2 = (t1 - bt.a + 256) % 256;
        else if (bt.a < bt.b) t2 = (t1 + bt.a) % 256;
        else if (bt.a != 0)   t2 = (t1 / bt.a + 1) % 256;
        else begin
            t2 = (255 + 1) % 256;
            d  = 1'b1;
        end
        if (bt.en) begin
            macc = ((bt.clr ? 0 : macc) + t2) % 256;
            x = 8'(macc);
        end else begin
            x = 8'(t2);
        end
        return 1'b1;
    endfunction

    task automatic rand_beat();
        A = 8'($urandom_range(0, 255));
        B = ($urandom_range(0, 3) == 0) ? A : 8'($urandom_range(0, 255));
        ACC_EN  = 1'($urandom_range(0, 1));
        ACC_CLR = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
        A = 8'd0; B = 8'd0; ACC_EN = 1'b0; ACC_CLR = 1'b0;
        tick();
        tick();
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", OUT_VALID); end
        checks++; if (XOUT !== 8'd0) begin errors++; $display("FAIL reset_xout got=%0d exp=0", XOUT); end
        checks++; if (DIVZ !== 1'b0) begin errors++; $display("FAIL reset_divz got=%b exp=0", DIVZ); end
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", IN_READY); end
        RST = 1'b0;
        q.delete();
        macc = 0;
    endtask

    task automatic test_directed();
        vec_t vecs[10];
        logic [7:0] mx;
        bit md;
        int mc;
        bit got;
        vecs = '{
            '{10, 3, 1'b0, 1'b0, 10, 1'b0},
            '{3, 10, 1'b0, 1'b0, 252, 1'b0},
            '{5, 5, 1'b0, 1'b0, 6, 1'b0},
            '{20, 20, 1'b0, 1'b0, 8, 1'b0},
            '{0, 0, 1'b0, 1'b0, 0, 1'b1},
            '{7, 1, 1'b0, 1'b0, 7, 1'b0},
            '{10, 3, 1'b1, 1'b1, 10, 1'b0},
            '{5, 5, 1'b1, 1'b0, 16, 1'b0},
            '{3, 10, 1'b0, 1'b0, 252, 1'b0},
            '{10, 3, 1'b1, 1'b0, 26, 1'b0}
        };
        OUT_READY = 1'b1;
        foreach (vecs[i]) begin
            A = 8'(vecs[i].a); B = 8'(vecs[i].b);
            ACC_EN = vecs[i].en; ACC_CLR = vecs[i].clr;
            IN_VALID = 1'b1;
            tick();
            checks++; if (s_in !== 1'b1) begin errors++; $display("FAIL dir%0d_accept got=%b exp=1", i, s_in); end
            IN_VALID = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 6 && !got; k++) begin
                tick();
                if (s_out) begin
                    got = 1'b1;
                    void'(model_pop(mx, md, mc));
                    checks++; if (s_cyc - mc != 2) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=2", i, s_cyc - mc); end
                    checks++; if (s_x !== 8'(vecs[i].x)) begin errors++; $display("FAIL dir%0d_xout got=%0d exp=%0d", i, s_x, vecs[i].x); end
                    checks++; if (s_d !== vecs[i].d) begin errors++; $display("FAIL dir%0d_divz got=%b exp=%b", i, s_d, vecs[i].d); end
                end
            end
            if (!got) begin checks++; errors++; $display("FAIL dir%0d_timeout got=no_output exp=output", i); end
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int rcvd = 0;
        bit pstall = 1'b0;
        logic [7:0] px = 8'd0;
        logic pd = 1'b0;
        logic [7:0] mx;
        bit md;
        int mc;
        rand_beat();
        IN_VALID = 1'b1;
        for (int c = 0; c < 40 && rcvd < 6; c++) begin
            OUT_READY = !(c >= 3 && c <= 5);
            tick();
            checks++;
            if (s_rdy !== !(s_occ == 2 && !s_ordy)) begin
                errors++; $display("FAIL bp_in_ready c=%0d got=%b exp=%b", c, s_rdy, !(s_occ == 2 && !s_ordy));
            end
            if (pstall) begin
                checks++;
                if (s_valid !== 1'b1 || s_x !== px || s_d !== pd) begin
                    errors++; $display("FAIL bp_hold c=%0d got=%b/%0d/%b exp=1/%0d/%b", c, s_valid, s_x, s_d, px, pd);
                end
            end
            pstall = s_valid && !s_ordy;
            px = s_x; pd = s_d;
            if (s_out) begin
                checks++;
                if (!model_pop(mx, md, mc)) begin
                    errors++; $display("FAIL bp_spurious got=%0d exp=none", s_x);
                end else if (s_x !== mx || s_d !== md) begin
                    errors++; $display("FAIL bp_data%0d got=%0d/%b exp=%0d/%b", rcvd, s_x, s_d, mx, md);
                end
                rcvd++;
            end
            if (s_in) begin
                sent++;
                if (sent < 6) rand_beat();
                else IN_VALID = 1'b0;
            end
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        checks++; if (rcvd != 6) begin errors++; $display("FAIL bp_count got=%0d exp=6", rcvd); end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] mx;
        bit md;
        int mc;
        bit got;
        OUT_READY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            A = 8'(40 + i); B = 8'd7; ACC_EN = 1'b1; ACC_CLR = 1'b0; IN_VALID = 1'b1;
            tick();
            checks++; if (s_in !== 1'b1) begin errors++; $display("FAIL rst_mid_accept%0d got=%b exp=1", i, s_in); end
        end
        IN_VALID = 1'b0; OUT_READY = 1'b0; RST = 1'b1;
        tick();
        RST = 1'b0; OUT_READY = 1'b1;
        q.delete();
        macc = 0;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got=%b exp=0", OUT_VALID); end
        checks++; if (XOUT !== 8'd0) begin errors++; $display("FAIL rst_mid_xout got=%0d exp=0", XOUT); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ghost%0d got=%b exp=0", k, s_valid); end
        end
        A = 8'd10; B = 8'd3; ACC_EN = 1'b1; ACC_CLR = 1'b0; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            tick();
            if (s_out) begin
                got = 1'b1;
                void'(model_pop(mx, md, mc));
                checks++; if (s_x !== 8'd10) begin errors++; $display("FAIL rst_mid_after got=%0d exp=10", s_x); end
                checks++; if (s_x !== mx) begin errors++; $display("FAIL rst_mid_model got=%0d exp=%0d", s_x, mx); end
            end
        end
        if (!got) begin checks++; errors++; $display("FAIL rst_mid_timeout got=no_output exp=output"); end
    endtask

    task automatic test_full_rate();
        int rcvd = 0;
        logic [7:0] mx;
        bit md;
        int mc;
        OUT_READY = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c < 16) begin rand_beat(); IN_VALID = 1'b1; end
            else IN_VALID = 1'b0;
            tick();
            if (c < 16) begin
                checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL fr_in_ready c=%0d got=%b exp=1", c, s_rdy); end
            end
            checks++;
            if (s_valid !== (c >= 2 && c < 18)) begin
                errors++; $display("FAIL fr_out_valid c=%0d got=%b exp=%b", c, s_valid, (c >= 2 && c < 18));
            end
            if (s_out) begin
                checks++;
                if (!model_pop(mx, md, mc)) begin
                    errors++; $display("FAIL fr_spurious got=%0d exp=none", s_x);
                end else if (s_x !== mx || s_d !== md || s_cyc - mc != 2) begin
                    errors++; $display("FAIL fr_data%0d got=%0d/%b/lat%0d exp=%0d/%b/lat2", rcvd, s_x, s_d, s_cyc - mc, mx, md);
                end
                rcvd++;
            end
        end
        checks++; if (rcvd != 16) begin errors++; $display("FAIL fr_count got=%0d exp=16", rcvd); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midstream();
        test_full_rate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
